// File: rtl/retry_pkg.sv
// Shared types and sizing helpers for the DMR retry join.
// Lane payload bundle and drop-credit width.
package retry_pkg;

    localparam int IDSize         = 2;
    localparam int DefDepth       = 2;
    localparam int DefSkewTimeout = 8;

    typedef logic [7:0] data_t;

    typedef struct packed {
        data_t             data;
        logic [IDSize-1:0] id;
    } retry_lane_t;

    function automatic int credit_width(input int depth);
        return $clog2(depth) + 2;
    endfunction

    localparam int CreditW = credit_width(DefDepth);

endpackage

// File: rtl/retry_dmr_lane_fifo.sv
// One DMR lane: registered FIFO plus a drop-credit counter that
// swallows late tokens belonging to an already-flushed pair.
module retry_dmr_lane_fifo
    import retry_pkg::*;
#(
    parameter int Depth = DefDepth
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  retry_lane_t in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        pop,
    input  logic        credit_inc,
    output retry_lane_t head,
    output logic        empty,
    output logic        credit_ovf
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam int CrW  = credit_width(Depth);
    localparam logic [CrW-1:0] CrMax = '1;

    retry_lane_t     mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic [CrW-1:0]  credit;
    logic            ovf_q;

    logic full;
    logic has_credit;
    logic accept;
    logic drop;
    logic push;
    logic do_pop;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = (count == CntW'(Depth));
    assign empty      = (count == '0);
    assign has_credit = (credit != '0);
    assign in_ready   = !full || has_credit;
    assign accept     = in_valid && in_ready;
    // A token arriving in the same cycle its partner is flushed is the late one
    assign drop       = accept && (has_credit || credit_inc);
    assign push       = accept && !drop;
    assign do_pop     = pop && !empty;
    assign head       = mem[rd_ptr];
    assign credit_ovf = ovf_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            unique case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit <= '0;
            ovf_q  <= 1'b0;
        end else if (credit_inc && !drop) begin
            if (credit != CrMax) begin
                credit <= credit + 1'b1;
            end else begin
                ovf_q <= 1'b1;
            end
        end else if (!credit_inc && drop) begin
            credit <= credit - 1'b1;
        end
    end

endmodule

// File: rtl/retry_dmr_join.sv
// Joins two redundant lane copies into one stream, flagging mismatches
// for retry and force-flushing a lane that leads by too long.
module retry_dmr_join
    import retry_pkg::*;
#(
    parameter int Depth       = DefDepth,
    parameter int SkewTimeout = DefSkewTimeout
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  data_t             a_data_i,
    input  logic [IDSize-1:0] a_id_i,
    input  logic              a_valid_i,
    output logic              a_ready_o,
    input  data_t             b_data_i,
    input  logic [IDSize-1:0] b_id_i,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    output data_t             data_o,
    output logic [IDSize-1:0] id_o,
    output logic              needs_retry_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              skew_error_o,
    output logic              credit_ovf_o
);

    localparam int SkW = $clog2(SkewTimeout + 1);
    localparam logic [SkW-1:0] SkMax = SkW'(SkewTimeout);

    retry_lane_t a_head;
    retry_lane_t b_head;
    logic        a_empty;
    logic        b_empty;
    logic        a_ovf;
    logic        b_ovf;
    logic        a_pop;
    logic        b_pop;
    logic        a_cinc;
    logic        b_cinc;

    logic [SkW-1:0] skew_cnt;
    logic           both;
    logic           one;
    logic           flush;
    logic           hs;

    retry_dmr_lane_fifo #(.Depth(Depth)) u_lane_a (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_data    ('{data: a_data_i, id: a_id_i}),
        .in_valid   (a_valid_i),
        .in_ready   (a_ready_o),
        .pop        (a_pop),
        .credit_inc (a_cinc),
        .head       (a_head),
        .empty      (a_empty),
        .credit_ovf (a_ovf)
    );

    retry_dmr_lane_fifo #(.Depth(Depth)) u_lane_b (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_data    ('{data: b_data_i, id: b_id_i}),
        .in_valid   (b_valid_i),
        .in_ready   (b_ready_o),
        .pop        (b_pop),
        .credit_inc (b_cinc),
        .head       (b_head),
        .empty      (b_empty),
        .credit_ovf (b_ovf)
    );

    assign both  = !a_empty && !b_empty;
    assign one   = a_empty ^ b_empty;
    // Normal join wins: flush only fires while exactly one lane holds data
    assign flush = one && (skew_cnt == SkMax);
    assign hs    = valid_o && ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            skew_cnt <= '0;
        end else if (!one || (hs && flush)) begin
            skew_cnt <= '0;
        end else if (skew_cnt != SkMax) begin
            skew_cnt <= skew_cnt + 1'b1;
        end
    end

    always_comb begin
        valid_o       = both || flush;
        data_o        = a_empty ? b_head.data : a_head.data;
        id_o          = a_empty ? b_head.id : a_head.id;
        needs_retry_o = both ? (a_head != b_head) : 1'b1;
        a_pop         = hs && !a_empty;
        b_pop         = hs && !b_empty;
        skew_error_o  = hs && flush;
        a_cinc        = hs && flush && a_empty;
        b_cinc        = hs && flush && b_empty;
        credit_ovf_o  = a_ovf || b_ovf;
    end

endmodule
